// File: rtl/led_code_queue_pkg.sv
// Shared definitions for the LED blink-code queue: FSM states, queue entry
// layout and the acknowledge timeout used while waiting for the flasher.
package led_code_queue_pkg;

  localparam int ENTRY_W     = 5;
  localparam int ACK_TIMEOUT = 7;
  localparam int TMO_W       = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic       fast;
    logic [3:0] code;
  } entry_t;

  // A zero blink count means "nothing to show".
  function automatic logic entry_valid(input entry_t e);
    return e.code != 4'd0;
  endfunction

endpackage

// File: rtl/led_code_fifo.sv
// Small FIFO of blink-code entries with level/full/empty and a drop strobe
// for valid pushes that arrive while full without a same-cycle pop.
module led_code_fifo
  import led_code_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  entry_t        push_data_i,
  input  logic          pop_i,
  output entry_t        head_o,
  output logic [AW:0]   level_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          drop_o
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q,  level_d;
  logic            push_valid, pop_ok, accept;

  assign full_o     = (level_q == DEPTH_L);
  assign empty_o    = (level_q == '0);
  assign push_valid = push_i && entry_valid(push_data_i);
  assign pop_ok     = pop_i && !empty_o;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign accept     = push_valid && (!full_o || pop_ok);
  assign drop_o     = push_valid && full_o && !pop_ok;
  assign head_o     = mem_q[rd_ptr_q];
  assign level_o    = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    if (accept && !pop_ok)      level_d = level_q + (AW+1)'(1);
    else if (!accept && pop_ok) level_d = level_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/led_code_queue.sv
// Queues blink codes for a downstream LED flasher and issues them one at a
// time, falling back to a persistent background code when the queue is empty.
module led_code_queue
  import led_code_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [3:0]    push_code,
  input  logic          push_fast,
  input  logic          sticky_set,
  input  logic [3:0]    sticky_code,
  input  logic          sticky_fast,
  input  logic          ovf_clr,
  input  logic          flash_busy,
  output logic [3:0]    mode,
  output logic          mode_fast,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty,
  output logic          overflow
);

  state_e            state_q;
  logic [3:0]        mode_q;
  logic              mode_fast_q;
  entry_t            sticky_q, sticky_d;
  logic              ovf_q, ovf_d;
  logic [TMO_W-1:0]  tmo_q;

  entry_t            push_entry, fifo_head;
  logic              fifo_pop, fifo_drop;

  assign push_entry = '{fast: push_fast, code: push_code};
  assign fifo_pop   = (state_q == IDLE) && !flash_busy && !empty;

  led_code_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .level_o     (level),
    .full_o      (full),
    .empty_o     (empty),
    .drop_o      (fifo_drop)
  );

  always_comb begin
    sticky_d = sticky_q;
    if (sticky_set) sticky_d = '{fast: sticky_fast, code: sticky_code};
    // A drop in the same cycle as a clear wins so no loss goes unreported.
    ovf_d = ovf_q;
    if (fifo_drop)    ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= 4'd0;
      mode_fast_q <= 1'b0;
      tmo_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!flash_busy) begin
            if (!empty) begin
              mode_q      <= fifo_head.code;
              mode_fast_q <= fifo_head.fast;
              state_q     <= ISSUE;
            end else if (entry_valid(sticky_q)) begin
              mode_q      <= sticky_q.code;
              mode_fast_q <= sticky_q.fast;
              state_q     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          mode_q  <= 4'd0;
          tmo_q   <= '0;
          state_q <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // A flasher that never answers must not stall the queue forever.
          if (flash_busy) begin
            tmo_q   <= '0;
            state_q <= WAIT_DONE;
          end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
            tmo_q   <= '0;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!flash_busy) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mode      = mode_q;
  assign mode_fast = mode_fast_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_led_code_queue.sv
// Directed self-checking bench for led_code_queue (DEPTH=4): issue ordering,
// overflow handling, persistent code, acknowledge timeout and reset.
module tb_led_code_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       push;
  logic [3:0] push_code;
  logic       push_fast;
  logic       sticky_set;
  logic [3:0] sticky_code;
  logic       sticky_fast;
  logic       ovf_clr;
  logic       flash_busy;
  logic [3:0] mode;
  logic       mode_fast;
  logic [2:0] level;
  logic       full;
  logic       empty;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_code_queue #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_code   (push_code),
    .push_fast   (push_fast),
    .sticky_set  (sticky_set),
    .sticky_code (sticky_code),
    .sticky_fast (sticky_fast),
    .ovf_clr     (ovf_clr),
    .flash_busy  (flash_busy),
    .mode        (mode),
    .mode_fast   (mode_fast),
    .level       (level),
    .full        (full),
    .empty       (empty),
    .overflow    (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    push = 0; push_code = 0; push_fast = 0;
    sticky_set = 0; sticky_code = 0; sticky_fast = 0;
    ovf_clr = 0; flash_busy = 0;
  endtask

  // Flasher answers one cycle of busy, then releases; ends back in IDLE.
  task automatic finish_ack();
    flash_busy = 1; tick();
    flash_busy = 0; tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    tick(); tick();
    checks++; if (mode !== 4'd0)  begin errors++; $display("FAIL reset_mode: got %0d expected 0", mode); end
    checks++; if (mode_fast !== 1'b0) begin errors++; $display("FAIL reset_fast: got %0b expected 0", mode_fast); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", empty); end
    checks++; if (full !== 1'b0)  begin errors++; $display("FAIL reset_full: got %0b expected 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", overflow); end
    rst = 0;
    tick();
    $display("reset released: mode=%0d level=%0d", mode, level);
  endtask

  task automatic test_basic_issue();
    flash_busy = 1;
    push = 1; push_code = 3; push_fast = 0; tick();
    push_code = 5; push_fast = 1; tick();
    push = 0;
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL basic_level2: got %0d expected 2", level); end
    checks++; if (mode !== 4'd0)  begin errors++; $display("FAIL basic_busy_hold: got %0d expected 0", mode); end
    flash_busy = 0; tick();
    $display("issue: mode=%0d fast=%0b level=%0d", mode, mode_fast, level);
    checks++; if (mode !== 4'd3)  begin errors++; $display("FAIL basic_mode3: got %0d expected 3", mode); end
    checks++; if (mode_fast !== 1'b0) begin errors++; $display("FAIL basic_fast0: got %0b expected 0", mode_fast); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL basic_level1: got %0d expected 1", level); end
    tick();
    checks++; if (mode !== 4'd0) begin errors++; $display("FAIL basic_pulse1: got %0d expected 0", mode); end
    flash_busy = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (mode !== 4'd0) begin errors++; $display("FAIL basic_busy_%0d: got %0d expected 0", i, mode); end
    end
    flash_busy = 0; tick();
    checks++; if (mode !== 4'd0) begin errors++; $display("FAIL basic_reidle: got %0d expected 0", mode); end
    tick();
    $display("issue: mode=%0d fast=%0b level=%0d", mode, mode_fast, level);
    checks++; if (mode !== 4'd5)  begin errors++; $display("FAIL basic_mode5: got %0d expected 5", mode); end
    checks++; if (mode_fast !== 1'b1) begin errors++; $display("FAIL basic_fast1: got %0b expected 1", mode_fast); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL basic_level0: got %0d expected 0", level); end
    tick();
    checks++; if (mode !== 4'd0)  begin errors++; $display("FAIL basic_pulse2: got %0d expected 0", mode); end
    checks++; if (mode_fast !== 1'b1) begin errors++; $display("FAIL basic_fast_hold: got %0b expected 1", mode_fast); end
    finish_ack();
  endtask

  task automatic test_overflow();
    logic [3:0] codes [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
    logic       fasts [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] exp_code [4] = '{4'd2, 4'd3, 4'd4, 4'd9};
    logic       exp_fast [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0] exp_lvl  [4] = '{3'd3, 3'd2, 3'd1, 3'd0};
    flash_busy = 1;
    for (int i = 0; i < 4; i++) begin
      push = 1; push_code = codes[i]; push_fast = fasts[i]; tick();
    end
    push = 0;
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level4: got %0d expected 4", level); end
    checks++; if (full !== 1'b1)  begin errors++; $display("FAIL ovf_full: got %0b expected 1", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre: got %0b expected 0", overflow); end
    push = 1; push_code = 5; push_fast = 0; tick(); push = 0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b expected 1", overflow); end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_drop_level: got %0d expected 4", level); end
    ovf_clr = 1; tick(); ovf_clr = 0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %0b expected 0", overflow); end
    push = 1; push_code = 0; tick(); push = 0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_zero_push: got %0b expected 0", overflow); end
    push = 1; push_code = 6; ovf_clr = 1; tick(); push = 0; ovf_clr = 0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_clr_vs_drop: got %0b expected 1", overflow); end
    ovf_clr = 1; tick(); ovf_clr = 0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr2: got %0b expected 0", overflow); end
    // Push lands in the same cycle the head is popped for issue.
    push = 1; push_code = 9; push_fast = 1; flash_busy = 0; tick(); push = 0;
    $display("issue: mode=%0d fast=%0b level=%0d", mode, mode_fast, level);
    checks++; if (mode !== 4'd1) begin errors++; $display("FAIL full_pop_mode: got %0d expected 1", mode); end
    checks++; if (mode_fast !== 1'b1) begin errors++; $display("FAIL full_pop_fast: got %0b expected 1", mode_fast); end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_pop_level: got %0d expected 4", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_pop_ovf: got %0b expected 0", overflow); end
    tick();
    finish_ack();
    for (int i = 0; i < 4; i++) begin
      tick();
      $display("issue: mode=%0d fast=%0b level=%0d", mode, mode_fast, level);
      checks++; if (mode !== exp_code[i]) begin errors++; $display("FAIL drain_mode_%0d: got %0d expected %0d", i, mode, exp_code[i]); end
      checks++; if (mode_fast !== exp_fast[i]) begin errors++; $display("FAIL drain_fast_%0d: got %0b expected %0b", i, mode_fast, exp_fast[i]); end
      checks++; if (level !== exp_lvl[i]) begin errors++; $display("FAIL drain_level_%0d: got %0d expected %0d", i, level, exp_lvl[i]); end
      tick();
      finish_ack();
    end
  endtask

  task automatic test_sticky();
    sticky_set = 1; sticky_code = 2; sticky_fast = 0; tick(); sticky_set = 0;
    tick();
    $display("issue: mode=%0d fast=%0b (sticky)", mode, mode_fast);
    checks++; if (mode !== 4'd2) begin errors++; $display("FAIL sticky_first: got %0d expected 2", mode); end
    tick();
    finish_ack();
    tick();
    checks++; if (mode !== 4'd2) begin errors++; $display("FAIL sticky_reissue: got %0d expected 2", mode); end
    tick();
    push = 1; push_code = 7; push_fast = 1; flash_busy = 1; tick();
    push = 0; flash_busy = 0; tick();
    tick();
    $display("issue: mode=%0d fast=%0b", mode, mode_fast);
    checks++; if (mode !== 4'd7)  begin errors++; $display("FAIL sticky_fifo_prio: got %0d expected 7", mode); end
    checks++; if (mode_fast !== 1'b1) begin errors++; $display("FAIL sticky_fifo_fast: got %0b expected 1", mode_fast); end
    tick();
    finish_ack();
    tick();
    checks++; if (mode !== 4'd2)  begin errors++; $display("FAIL sticky_after_fifo: got %0d expected 2", mode); end
    checks++; if (mode_fast !== 1'b0) begin errors++; $display("FAIL sticky_after_fast: got %0b expected 0", mode_fast); end
    tick();
    sticky_set = 1; sticky_code = 0; flash_busy = 1; tick();
    sticky_set = 0; flash_busy = 0; tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (mode !== 4'd0) begin errors++; $display("FAIL sticky_stop_%0d: got %0d expected 0", i, mode); end
    end
  endtask

  task automatic test_timeout();
    flash_busy = 0;
    push = 1; push_code = 6; push_fast = 0; tick();
    push_code = 8; push_fast = 1; tick(); push = 0;
    $display("issue: mode=%0d fast=%0b level=%0d", mode, mode_fast, level);
    checks++; if (mode !== 4'd6) begin errors++; $display("FAIL tmo_first: got %0d expected 6", mode); end
    // Seven WAIT_ACK cycles plus the return to IDLE before the next issue.
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (mode !== 4'd0) begin errors++; $display("FAIL tmo_wait_%0d: got %0d expected 0", i, mode); end
    end
    tick();
    $display("issue: mode=%0d fast=%0b level=%0d", mode, mode_fast, level);
    checks++; if (mode !== 4'd8)  begin errors++; $display("FAIL tmo_next: got %0d expected 8", mode); end
    checks++; if (mode_fast !== 1'b1) begin errors++; $display("FAIL tmo_next_fast: got %0b expected 1", mode_fast); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL tmo_level: got %0d expected 0", level); end
    tick();
    finish_ack();
  endtask

  task automatic test_reset_mid();
    logic [3:0] codes [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    flash_busy = 1;
    sticky_set = 1; sticky_code = 5; sticky_fast = 1;
    for (int i = 0; i < 5; i++) begin
      push = 1; push_code = codes[i]; push_fast = (i == 0); tick();
      sticky_set = 0;
    end
    push = 0;
    flash_busy = 0; tick();
    tick();
    flash_busy = 1; tick();
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL rmid_level_pre: got %0d expected 3", level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL rmid_ovf_pre: got %0b expected 1", overflow); end
    checks++; if (mode_fast !== 1'b1) begin errors++; $display("FAIL rmid_fast_pre: got %0b expected 1", mode_fast); end
    rst = 1; #1;
    checks++; if (mode !== 4'd0)  begin errors++; $display("FAIL rmid_mode: got %0d expected 0", mode); end
    checks++; if (mode_fast !== 1'b0) begin errors++; $display("FAIL rmid_fast: got %0b expected 0", mode_fast); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rmid_level: got %0d expected 0", level); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rmid_empty: got %0b expected 1", empty); end
    checks++; if (full !== 1'b0)  begin errors++; $display("FAIL rmid_full: got %0b expected 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rmid_ovf: got %0b expected 0", overflow); end
    flash_busy = 0;
    tick();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (mode !== 4'd0) begin errors++; $display("FAIL rmid_no_pulse_%0d: got %0d expected 0", i, mode); end
    end
    $display("reset mid-operation: level=%0d empty=%0b", level, empty);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_basic_issue();
    test_overflow();
    test_sticky();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
